// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//
// Idle-detect enable generator feeding a latch-based clock gate. It watches the gated unit's
// busy flag and closes the unit clock after IDLE_THRESH consecutive idle cycles. A wake
// request or force_on reopens the clock, and wake_ack follows once the clock has run for
// WAKE_LAT cycles.
//
// Parameters
//   IDLE_THRESH  consecutive idle cycles before gating (>= 1)
//   WAKE_LAT     cycles clock_enable is high in WAKING before wake_ack rises (>= 1)
//   STAT_W       width of the saturating gate-event counter
//
// Ports
//   clock         in   free-running (ungated) clock
//   reset         in   asynchronous reset, active-high
//   force_on      in   debug/DFT override: keep or reopen the clock
//   unit_busy     in   gated unit has work in flight (ignored while gated or waking)
//   wake_req      in   level request to use the gated unit
//   wake_ack      out  unit clock running and stable
//   clock_enable  out  enable into the clock gate latch (flop output, glitch-free)
//   gated         out  high while the unit clock is stopped
//   gate_events   out  number of entries into the gated state, saturating
//
// All outputs are flops loaded from the next-state value, so they are exact decodes of the
// registered state with no input-to-output combinational path.

module clock_gate_ctrl #(
  parameter int unsigned IDLE_THRESH = 16,
  parameter int unsigned WAKE_LAT    = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              force_on,
  input  logic              unit_busy,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              clock_enable,
  output logic              gated,
  output logic [STAT_W-1:0] gate_events
);

  // One width serves both counters; neither ever counts past its terminal value.
  localparam int unsigned CntMax = (IDLE_THRESH > WAKE_LAT) ? IDLE_THRESH : WAKE_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]   IdleLast = CntW'(IDLE_THRESH - 1);
  localparam logic [CntW-1:0]   WakeLast = CntW'(WAKE_LAT - 1);
  localparam logic [STAT_W-1:0] EvMax    = '1;

  typedef enum logic [1:0] {
    StActive    = 2'd0,
    StCountdown = 2'd1,
    StGated     = 2'd2,
    StWaking    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CntW-1:0] wake_cnt_q, wake_cnt_d;
  logic            gate_entry;
  logic            idle;

  assign idle = !unit_busy && !wake_req && !force_on;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_entry = 1'b0;

    case (state_q)
      StActive: begin
        if (idle) begin
          if (IDLE_THRESH == 1) begin
            state_d    = StGated;
            idle_cnt_d = '0;
            gate_entry = 1'b1;
          end else begin
            state_d    = StCountdown;
            idle_cnt_d = CntW'(1);
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      StCountdown: begin
        if (!idle) begin
          // Any activity, including on the threshold edge itself, cancels gating.
          state_d    = StActive;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          state_d    = StGated;
          idle_cnt_d = '0;
          gate_entry = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end

      StGated: begin
        // unit_busy is meaningless here: the unit has no clock.
        if (wake_req || force_on) begin
          state_d    = StWaking;
          wake_cnt_d = '0;
        end
      end

      StWaking: begin
        // Runs to completion even if wake_req drops mid-sequence.
        if (wake_cnt_q == WakeLast) begin
          state_d    = StActive;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d    = StActive;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StActive;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      gate_events  <= '0;
      clock_enable <= 1'b1;
      wake_ack     <= 1'b1;
      gated        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      clock_enable <= (state_d != StGated);
      wake_ack     <= (state_d == StActive) || (state_d == StCountdown);
      gated        <= (state_d == StGated);
      if (gate_entry && (gate_events != EvMax)) begin
        gate_events <= gate_events + STAT_W'(1);
      end
    end
  end

endmodule
